// File: rtl/asg_seq.sv
// asg_seq -- segment sequencer for one arbitrary signal generator channel.
// Plays table segments 0..cfg_nsg through the generator's ctl_rst and trigger
// inputs. Each segment can repeat, and the sequencer advances on the
// generator stop interrupt (asg_end). Optional feature: define
// ASG_SEQ_TIMEOUT_EN to add the RUN watchdog (cfg_tmo / sts_tmo). Without it,
// sts_tmo is tied low and cfg_tmo is ignored.
module asg_seq #(
    parameter int SN  = 8,
    parameter int CWM = 14,
    parameter int CWF = 16,
    parameter int CWN = 16,
    parameter int CWR = 8,
    parameter int CWT = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ctl_str,
    input  logic                  ctl_stp,
    input  logic [$clog2(SN)-1:0] cfg_nsg,
    input  logic                  cfg_lop,
    input  logic [CWT-1:0]        cfg_tmo,
    input  logic                  tbl_wen,
    input  logic [$clog2(SN)-1:0] tbl_adr,
    input  logic [CWM+CWF-1:0]    tbl_off,
    input  logic [CWM+CWF-1:0]    tbl_stp,
    input  logic [CWN-1:0]        tbl_bnm,
    input  logic [CWR-1:0]        tbl_rpt,
    input  logic                  asg_end,
    output logic                  asg_rst,
    output logic                  asg_trg,
    output logic [CWM+CWF-1:0]    asg_off,
    output logic [CWM+CWF-1:0]    asg_stp,
    output logic [CWN-1:0]        asg_bnm,
    output logic                  sts_bsy,
    output logic [$clog2(SN)-1:0] sts_seg,
    output logic [CWR-1:0]        sts_rpt,
    output logic                  sts_tmo,
    output logic                  irq_end
);

    localparam int SW = $clog2(SN);
    localparam int CW = CWM + CWF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RST,
        ST_TRG,
        ST_RUN
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  seg_q, seg_d;
    logic [CWR-1:0] rpt_q, rpt_d;
    logic [CWR-1:0] lim_q, lim_d;
    logic [CW-1:0]  off_q, off_d;
    logic [CW-1:0]  stp_q, stp_d;
    logic [CWN-1:0] bnm_q, bnm_d;
    logic           rst_q, rst_d;
    logic           trg_q, trg_d;
    logic           bsy_q, bsy_d;
    logic           irq_q, irq_d;
    logic           abort;
    logic           tmo_hit;

    logic [CW-1:0]  tbl_off_q [SN];
    logic [CW-1:0]  tbl_stp_q [SN];
    logic [CWN-1:0] tbl_bnm_q [SN];
    logic [CWR-1:0] tbl_rpt_q [SN];

    // Segment table: written at any time, consumed only when LOAD latches an entry.
    // NOTE: the table is deliberately reset like ordinary flops. A sequence
    // started after reset then plays all-zero segments instead of power-up junk.
    // NOTE: clocked state is assigned with non-blocking (<=) only. All flops
    // then update together at the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SN; i++) begin
                tbl_off_q[i] <= '0;
                tbl_stp_q[i] <= '0;
                tbl_bnm_q[i] <= '0;
                tbl_rpt_q[i] <= '0;
            end
        end else if (tbl_wen) begin
            tbl_off_q[tbl_adr] <= tbl_off;
            tbl_stp_q[tbl_adr] <= tbl_stp;
            tbl_bnm_q[tbl_adr] <= tbl_bnm;
            tbl_rpt_q[tbl_adr] <= tbl_rpt;
        end
    end

    // Next-state logic plus next values of every registered output.
    always_comb begin
        // NOTE: every variable is defaulted before the case. No path can leave
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        seg_d   = seg_q;
        rpt_d   = rpt_q;
        lim_d   = lim_q;
        off_d   = off_q;
        stp_d   = stp_q;
        bnm_d   = bnm_q;
        irq_d   = 1'b0;
        abort   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A simultaneous stop cancels the start.
                if (ctl_str && !ctl_stp) begin
                    seg_d   = '0;
                    rpt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                off_d   = tbl_off_q[seg_q];
                stp_d   = tbl_stp_q[seg_q];
                bnm_d   = tbl_bnm_q[seg_q];
                lim_d   = tbl_rpt_q[seg_q];
                state_d = ST_RST;
            end
            ST_RST: state_d = ST_TRG;
            ST_TRG: state_d = ST_RUN;
            ST_RUN: begin
                if (asg_end) begin
                    if (rpt_q != lim_q) begin
                        rpt_d   = rpt_q + CWR'(1);
                        state_d = ST_RST;
                    end else if (seg_q < cfg_nsg) begin
                        // The '<' test treats a live cfg_nsg lowered below the
                        // current segment as "last segment", so seg never wraps.
                        seg_d   = seg_q + SW'(1);
                        rpt_d   = '0;
                        state_d = ST_LOAD;
                    end else if (cfg_lop) begin
                        seg_d   = '0;
                        rpt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        irq_d   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctl_stp && (state_q != ST_IDLE)) begin
            abort = 1'b1;
        end

        // An abort freezes seg, rpt and the asg_* values for readback.
        if (abort) begin
            state_d = ST_IDLE;
            seg_d   = seg_q;
            rpt_d   = rpt_q;
            lim_d   = lim_q;
            off_d   = off_q;
            stp_d   = stp_q;
            bnm_d   = bnm_q;
            irq_d   = 1'b0;
        end

        // An abort holds the generator in reset for one cycle.
        rst_d = (state_d == ST_RST) || abort;
        trg_d = (state_d == ST_TRG);
        bsy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered Moore outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            rpt_q   <= '0;
            lim_q   <= '0;
            off_q   <= '0;
            stp_q   <= '0;
            bnm_q   <= '0;
            rst_q   <= 1'b0;
            trg_q   <= 1'b0;
            bsy_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            rpt_q   <= rpt_d;
            lim_q   <= lim_d;
            off_q   <= off_d;
            stp_q   <= stp_d;
            bnm_q   <= bnm_d;
            rst_q   <= rst_d;
            trg_q   <= trg_d;
            bsy_q   <= bsy_d;
            irq_q   <= irq_d;
        end
    end

`ifdef ASG_SEQ_TIMEOUT_EN
    logic [CWT-1:0] wdg_q, wdg_d;
    logic           tmo_q, tmo_d;

    // Expiry fires on the RUN cycle whose count would reach cfg_tmo.
    // This puts asg_rst exactly cfg_tmo cycles after RUN entry.
    assign tmo_hit = (state_q == ST_RUN) && (cfg_tmo != '0) &&
                     ((wdg_q + CWT'(1)) == cfg_tmo);

    // Watchdog next values: cleared outside RUN, saturating count in RUN,
    // and a sticky flag cleared by an accepted start.
    always_comb begin
        wdg_d = '0;
        if ((state_q == ST_RUN) && (wdg_q != '1)) begin
            wdg_d = wdg_q + CWT'(1);
        end else if (state_q == ST_RUN) begin
            wdg_d = wdg_q;
        end
        tmo_d = tmo_q;
        if ((state_q == ST_IDLE) && ctl_str && !ctl_stp) begin
            tmo_d = 1'b0;
        end else if (tmo_hit && !asg_end) begin
            tmo_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdg_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            wdg_q <= wdg_d;
            tmo_q <= tmo_d;
        end
    end

    assign sts_tmo = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^cfg_tmo;
    assign tmo_hit    = 1'b0;
    assign sts_tmo    = 1'b0;
`endif

    assign asg_rst = rst_q;
    assign asg_trg = trg_q;
    assign asg_off = off_q;
    assign asg_stp = stp_q;
    assign asg_bnm = bnm_q;
    assign sts_bsy = bsy_q;
    assign sts_seg = seg_q;
    assign sts_rpt = rpt_q;
    assign irq_end = irq_q;

endmodule

// File: tb/tb_asg_seq.sv
// Directed self-checking bench for asg_seq. Inputs change and outputs are
// sampled on the falling edge, which keeps them clear of the active rising edge.
module tb_asg_seq;

    localparam int SN  = 8;
    localparam int CWM = 14;
    localparam int CWF = 16;
    localparam int CWN = 16;
    localparam int CWR = 8;
    localparam int CWT = 32;
    localparam int SW  = $clog2(SN);
    localparam int CW  = CWM + CWF;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           ctl_str = 1'b0;
    logic           ctl_stp = 1'b0;
    logic [SW-1:0]  cfg_nsg = '0;
    logic           cfg_lop = 1'b0;
    logic [CWT-1:0] cfg_tmo = '0;
    logic           tbl_wen = 1'b0;
    logic [SW-1:0]  tbl_adr = '0;
    logic [CW-1:0]  tbl_off = '0;
    logic [CW-1:0]  tbl_stp = '0;
    logic [CWN-1:0] tbl_bnm = '0;
    logic [CWR-1:0] tbl_rpt = '0;
    logic           asg_end = 1'b0;
    logic           asg_rst, asg_trg, sts_bsy, sts_tmo, irq_end;
    logic [CW-1:0]  asg_off, asg_stp;
    logic [CWN-1:0] asg_bnm;
    logic [SW-1:0]  sts_seg;
    logic [CWR-1:0] sts_rpt;

    int n_vec = 0;
    int n_err = 0;

    asg_seq #(
        .SN(SN), .CWM(CWM), .CWF(CWF), .CWN(CWN), .CWR(CWR), .CWT(CWT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ctl_str(ctl_str), .ctl_stp(ctl_stp),
        .cfg_nsg(cfg_nsg), .cfg_lop(cfg_lop), .cfg_tmo(cfg_tmo),
        .tbl_wen(tbl_wen), .tbl_adr(tbl_adr), .tbl_off(tbl_off),
        .tbl_stp(tbl_stp), .tbl_bnm(tbl_bnm), .tbl_rpt(tbl_rpt),
        .asg_end(asg_end),
        .asg_rst(asg_rst), .asg_trg(asg_trg),
        .asg_off(asg_off), .asg_stp(asg_stp), .asg_bnm(asg_bnm),
        .sts_bsy(sts_bsy), .sts_seg(sts_seg), .sts_rpt(sts_rpt),
        .sts_tmo(sts_tmo), .irq_end(irq_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tbl_write(input int idx, input logic [CW-1:0] off, input logic [CW-1:0] stp,
                             input logic [CWN-1:0] bnm, input logic [CWR-1:0] rpt);
        tbl_adr = SW'(idx);
        tbl_off = off;
        tbl_stp = stp;
        tbl_bnm = bnm;
        tbl_rpt = rpt;
        tbl_wen = 1'b1;
        tick();
        tbl_wen = 1'b0;
    endtask

    // Returns in cycle 1 of the sequence (LOAD).
    task automatic start_seq();
        ctl_str = 1'b1;
        tick();
        ctl_str = 1'b0;
    endtask

    task automatic end_pulse();
        asg_end = 1'b1;
        tick();
        asg_end = 1'b0;
    endtask

    // Hard stop in case something wedges the run.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [CW-1:0] exp_off [3];
        int got;
        exp_off[0] = CW'('h100);
        exp_off[1] = CW'('h200);
        exp_off[2] = CW'('h300);

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_flags", {asg_rst, asg_trg, sts_bsy, sts_tmo, irq_end}, 0);
        check("rst_off", asg_off, 0);
        check("rst_stp_bnm", {asg_stp, asg_bnm}, 0);
        check("rst_seg_rpt", {sts_seg, sts_rpt}, 0);
        rstn = 1'b1;
        tick();

        // ---------------- basic three-segment sequence ----------------
        tbl_write(0, CW'('h100), CW'('h10), 16'd4, 8'd0);
        tbl_write(1, CW'('h200), CW'('h20), 16'd5, 8'd0);
        tbl_write(2, CW'('h300), CW'('h30), 16'd6, 8'd0);
        cfg_nsg = SW'(2);
        cfg_lop = 1'b0;
        start_seq();
        for (int s = 0; s < 3; s++) begin
            check("t1_load_rst", asg_rst, 0);
            check("t1_load_bsy", sts_bsy, 1);
            tick();
            check("t1_rst", asg_rst, 1);
            check("t1_off", asg_off, exp_off[s]);
            check("t1_stp", asg_stp, 'h10 * (s + 1));
            check("t1_bnm", asg_bnm, 4 + s);
            check("t1_seg", sts_seg, s);
            tick();
            check("t1_trg", {asg_trg, asg_rst}, 2'b10);
            repeat (20) tick();
            check("t1_run_irq", irq_end, 0);
            end_pulse();
        end
        check("t1_irq", irq_end, 1);
        check("t1_bsy_fall", sts_bsy, 0);
        tick();
        check("t1_irq_once", irq_end, 0);
        check("t1_idle", {sts_bsy, asg_rst, asg_trg}, 0);

        // ---------------- repeat: segment 0 plays four times ----------------
        tbl_write(0, CW'('hAB), CW'('h7), 16'd3, 8'd3);
        cfg_nsg = SW'(0);
        start_seq();
        tick();
        check("t2_rst", asg_rst, 1);
        tick();
        for (int r = 0; r < 4; r++) begin
            check("t2_trg", asg_trg, 1);
            check("t2_rpt", sts_rpt, r);
            check("t2_off", asg_off, 'hAB);
            repeat (5) tick();
            end_pulse();
            if (r < 3) begin
                check("t2_turn_rst", {asg_rst, asg_trg}, 2'b10);
                tick();
            end else begin
                check("t2_irq", irq_end, 1);
            end
        end
        tick();

        // ---------------- loop and abort ----------------
        tbl_write(0, CW'('h100), CW'('h10), 16'd4, 8'd0);
        cfg_nsg = SW'(1);
        cfg_lop = 1'b1;
        start_seq();
        for (int k = 0; k < 5; k++) begin
            tick();
            tick();
            check("t3_trg", asg_trg, 1);
            check("t3_seg", sts_seg, k % 2);
            check("t3_off", asg_off, (k % 2) ? 'h200 : 'h100);
            repeat (3) tick();
            end_pulse();
            check("t3_no_irq", irq_end, 0);
            check("t3_bsy", sts_bsy, 1);
        end
        repeat (3) tick();
        ctl_stp = 1'b1;
        tick();
        ctl_stp = 1'b0;
        check("t3_stop_rst", asg_rst, 1);
        check("t3_stop_idle", {sts_bsy, irq_end}, 0);
        check("t3_keep_seg", sts_seg, 1);
        check("t3_keep_off", asg_off, 'h200);
        tick();
        check("t3_rst_once", {asg_rst, sts_bsy, irq_end}, 0);

        // ---------------- simultaneous events ----------------
        cfg_lop = 1'b0;
        cfg_nsg = SW'(0);
        ctl_str = 1'b1;
        ctl_stp = 1'b1;
        tick();
        ctl_str = 1'b0;
        ctl_stp = 1'b0;
        check("t4_strstp_a", {sts_bsy, asg_rst}, 0);
        tick();
        check("t4_strstp_b", {sts_bsy, asg_rst}, 0);

        start_seq();
        repeat (3) tick();
        ctl_str = 1'b1;
        tick();
        ctl_str = 1'b0;
        check("t4_busy_str_a", {sts_bsy, asg_rst, asg_trg}, 3'b100);
        tick();
        check("t4_busy_str_b", {sts_bsy, asg_rst, asg_trg}, 3'b100);
        end_pulse();
        check("t4_busy_str_irq", irq_end, 1);
        tick();

        ctl_str = 1'b1;
        tick();
        ctl_str = 1'b0;
        asg_end = 1'b1;
        tick();
        asg_end = 1'b0;
        check("t4_load_end", {asg_rst, sts_bsy, irq_end}, 3'b110);
        tick();
        check("t4_load_end_trg", asg_trg, 1);
        tick();
        check("t4_load_end_run", sts_bsy, 1);
        end_pulse();
        check("t4_load_end_irq", irq_end, 1);
        tick();

        // ---------------- watchdog ----------------
        cfg_tmo = CWT'(50);
        start_seq();
        repeat (3) tick();
`ifdef ASG_SEQ_TIMEOUT_EN
        got = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (asg_rst === 1'b1) begin
                got = i;
                break;
            end
        end
        check("t5_tmo_latency", got, 50);
        check("t5_tmo_flag", {sts_tmo, sts_bsy}, 2'b10);
        repeat (5) tick();
        check("t5_tmo_sticky", sts_tmo, 1);
        start_seq();
        check("t5_tmo_clear", sts_tmo, 0);
        ctl_stp = 1'b1;
        tick();
        ctl_stp = 1'b0;
`else
        got = 0;
        repeat (100) tick();
        check("t5_no_tmo", {sts_bsy, sts_tmo, asg_rst}, 3'b100);
        ctl_stp = 1'b1;
        tick();
        ctl_stp = 1'b0;
        check("t5_no_tmo_stop", sts_bsy, 0);
`endif
        cfg_tmo = '0;
        tick();

        // ---------------- reset mid-RUN ----------------
        cfg_nsg = SW'(0);
        start_seq();
        repeat (3) tick();
        check("t6_pre_off", asg_off, 'h100);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async_flags", {asg_rst, asg_trg, sts_bsy, sts_tmo, irq_end}, 0);
        check("t6_async_off", {asg_off, asg_stp, asg_bnm}, 0);
        tick();
        rstn = 1'b1;
        tick();
        start_seq();
        tick();
        check("t6_tbl_rst", asg_rst, 1);
        check("t6_tbl_zero", {asg_off, asg_stp, asg_bnm}, 0);
        tick();
        tick();
        end_pulse();
        check("t6_irq", irq_end, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/asg_seq.md
# asg_seq

Segment sequencer for one arbitrary signal generator channel. It holds a small table of waveform segments, each with phase offset, step, burst repetitions and segment repeat count. It drives the channel's `ctl_rst`, trigger bit and `cfg_off`/`cfg_stp`/`cfg_bnm` inputs, and advances on the channel's stop interrupt. It sits between the register map and the generator channel, so a multi-segment waveform plays without CPU intervention.

## Interface
- `SN`, 8: number of table segments; power of two, 2..64.
- `CWM`, 14: pointer magnitude width; matches the generator.
- `CWF`, 16: pointer fraction width; matches the generator.
- `CWN`, 16: burst repetition counter width.
- `CWR`, 8: segment repeat counter width.
- `CWT`, 32: timeout counter width.

Ports:
- `clk`  in  1  clock, same as the generator stream clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `ctl_str`  in  1  start pulse.
- `ctl_stp`  in  1  stop/abort pulse.
- `cfg_nsg`  in  $clog2(SN)  index of last segment (segments 0..`cfg_nsg` play).
- `cfg_lop`  in  1  loop to segment 0 after last.
- `cfg_tmo`  in  CWT  RUN watchdog limit in cycles.
- `tbl_wen`  in  1  table write strobe.
- `tbl_adr`  in  $clog2(SN)  table write index.
- `tbl_off`  in  CWM+CWF  segment offset.
- `tbl_stp`  in  CWM+CWF  segment step.
- `tbl_bnm`  in  CWN  segment burst repetitions.
- `tbl_rpt`  in  CWR  segment repeat count (plays `tbl_rpt`+1 times).
- `asg_end`  in  1  generator stop interrupt (`irq_stp`).
- `asg_rst`  out  1  to generator `ctl_rst`.
- `asg_trg`  out  1  to one generator `trg_i` bit.
- `asg_off`  out  CWM+CWF  segment offset.
- `asg_stp`  out  CWM+CWF  segment step.
- `asg_bnm`  out  CWN  segment burst repetitions.
- `sts_bsy`  out  1  sequence active.
- `sts_seg`  out  $clog2(SN)  current segment.
- `sts_rpt`  out  CWR  current repeat index.
- `sts_tmo`  out  1  sticky timeout flag.
- `irq_end`  out  1  one-cycle pulse on normal completion.

## Operation
- Table: SN entries in registers, written when `tbl_wen` is high, at any time. A write takes effect at the next LOAD of that index.
- FSM states: IDLE, LOAD, RST, TRG, RUN.
  - IDLE: on `ctl_str`, clear seg and rpt, then go to LOAD.
  - LOAD: latch `table[seg]` into the `asg_off`, `asg_stp` and `asg_bnm` registers and the internal rpt limit, then go to RST.
  - RST: go to TRG.
  - TRG: go to RUN.
  - RUN: act on `asg_end`:
    - if rpt ≠ limit: rpt+1, go to RST (same config);
    - else if seg ≠ `cfg_nsg`: seg+1, rpt=0, go to LOAD;
    - else if `cfg_lop`: seg=0, rpt=0, go to LOAD;
    - else go to IDLE and pulse `irq_end`.
- Outputs:
  - `asg_rst` = state==RST.
  - `asg_trg` = state==TRG.
  - `sts_bsy` = state≠IDLE.
- All outputs are Moore and taken from registers; no combinational path from inputs.
- `ctl_stp` in any non-IDLE state:
  - next state is IDLE and `asg_rst` is held for exactly one cycle;
  - no `irq_end` pulse;
  - seg, rpt and the `asg_*` values are kept for readback.
- Simultaneous events:
  - `ctl_str` together with `ctl_stp`: stop wins.
  - `ctl_str` while busy: ignored.
  - `asg_end` outside RUN: ignored.
- `cfg_nsg` and `cfg_lop` are sampled live at the decision in RUN.
- Arithmetic: seg and rpt increments never wrap silently. seg wraps only through the `cfg_lop` path. `cfg_nsg` ≥ SN is impossible by width.

## Timing
- Reset (`rstn` low, async):
  - state IDLE;
  - every output 0, including `asg_off`, `asg_stp` and `asg_bnm`;
  - table contents 0.
- Reset asserted mid-sequence: the FSM returns immediately to IDLE. The generator is reset separately by the system reset.
- Start latency: `ctl_str` sampled at edge 0.
  - LOAD in cycle 1.
  - `asg_*` values valid and `asg_rst`=1 in cycle 2.
  - `asg_trg`=1 in cycle 3.
  - RUN from cycle 4.
- Repeat turnaround: `asg_end` at edge n gives `asg_rst` at n+1 and `asg_trg` at n+2.
- Segment change: 3-cycle gap from `asg_end` to `asg_trg`.
- `irq_end` is high in the cycle after the final `asg_end`, and `sts_bsy` falls in that same cycle.
- The generator must be in finite burst mode with `cfg_ben`=1; otherwise `asg_end` never fires.

## Configuration
- `ASG_SEQ_TIMEOUT_EN` defined:
  - a CWT watchdog counter clears on entry to RUN and increments each RUN cycle;
  - when it reaches `cfg_tmo` without `asg_end`, the block behaves as `ctl_stp` and sets `sts_tmo`;
  - `sts_tmo` clears on `ctl_str`;
  - `cfg_tmo`=0 disables the watchdog.
- `ASG_SEQ_TIMEOUT_EN` undefined: no counter; `cfg_tmo` is ignored; `sts_tmo` is tied 0.

## Test plan
- Basic sequence:
  - stimulus: `cfg_nsg`=2, `cfg_lop`=0, rpt=0 on all segments, distinct offsets 0x100/0x200/0x300; `ctl_str`, then `asg_end` 20 cycles after each `asg_trg`;
  - required: three RST/TRG pairs with `asg_off` 0x100, 0x200, 0x300 in order; `irq_end` one cycle after the third `asg_end`; `sts_bsy` low after that.
- Repeat:
  - stimulus: segment 0 with `tbl_rpt`=3;
  - required: 4 triggers with `asg_off` unchanged; `sts_rpt` reads 0, 1, 2, 3; 2-cycle `asg_end`→`asg_trg` gap between repeats.
- Loop and abort:
  - stimulus: `cfg_lop`=1, `cfg_nsg`=1; after 5 `asg_end` pulses assert `ctl_stp`;
  - required: `sts_seg` sequence 0, 1, 0, 1, 0; one `asg_rst` pulse on stop; no `irq_end`; IDLE next cycle.
- Simultaneous start and stop:
  - stimulus: `ctl_str`=`ctl_stp`=1 in IDLE;
  - required: stays IDLE, no `asg_rst`.
  - stimulus: `ctl_str` during RUN;
  - required: no effect.
  - stimulus: `asg_end` during LOAD;
  - required: ignored.
- Timeout (macro on):
  - stimulus: `cfg_tmo`=50, no `asg_end`;
  - required: `asg_rst` 50 cycles after RUN entry; `sts_tmo`=1 until the next `ctl_str`.
  - macro off: `sts_tmo` stays 0 and the block waits indefinitely.
- Reset mid-RUN:
  - stimulus: drop `rstn` during RUN;
  - required: all outputs 0 asynchronously; table entries read back 0 on the next sequence.
